// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Package : cache_pkg
// Brief   : Shared L1/L2 cache types and line-geometry constants.
// Rev     : 1.0  initial release
// ============================================================================
package cache_pkg;

  localparam int BURST_LEN  = 8;
  localparam int LINE_OFF_W = $clog2(BURST_LEN) + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_P = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Combinational two-way round-robin pick between L1D and L1P.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb2
  import cache_pkg::*;
(
  input  logic d_req,
  input  logic p_req,
  input  logic last_owner,
  output logic pick
);

  // On a tie the side that did not own the last burst wins.
  always_comb begin
    pick = OWN_D;
    if (d_req && p_req) begin
      pick = (last_owner == OWN_P) ? OWN_D : OWN_P;
    end else if (p_req) begin
      pick = OWN_P;
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : l2_port_arbiter
// Brief  : Shares the L2 port between L1D and L1P, one full line burst per grant.
// Rev    : 1.0  initial release
// ============================================================================
module l2_port_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = cache_pkg::BURST_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_beat,
  output logic              d_done,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  output logic              p_gnt,
  output logic              p_beat,
  output logic              p_done,
  output logic [DATA_W-1:0] rdata,
  output logic              l2_req,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic              l2_ack,
  input  logic [DATA_W-1:0] l2_rdata
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int OFF    = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] ONE_BEAT  = BEAT_W'(1);

  arb_state_e              r_state;
  arb_state_e              w_state_next;
  logic [BEAT_W-1:0]       r_beat_idx;
  logic                    r_owner;
  logic                    r_last_owner;
  logic                    r_we;
  logic [ADDR_W-OFF-1:0]   r_line_addr;
  logic                    w_pick;
  logic                    w_burst;
  logic                    w_done;
  logic                    w_own_d;
  logic                    w_ack_beat;
  logic                    w_addr_unused;

  assign w_addr_unused = ^{d_addr[OFF-1:0], p_addr[OFF-1:0]};

  rr_arb2 u_rr_arb2 (
    .d_req      (d_req),
    .p_req      (p_req),
    .last_owner (r_last_owner),
    .pick       (w_pick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (d_req || p_req) w_state_next = BURST;
      BURST:   if (l2_ack && (r_beat_idx == LAST_BEAT)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Owner, direction and line are frozen at grant; requester changes mid-burst are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_beat_idx   <= '0;
      r_owner      <= OWN_D;
      r_last_owner <= OWN_P;
      r_we         <= 1'b0;
      r_line_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (d_req || p_req) begin
            r_owner     <= w_pick;
            r_we        <= (w_pick == OWN_D) ? d_we : 1'b0;
            r_line_addr <= (w_pick == OWN_D) ? d_addr[ADDR_W-1:OFF] : p_addr[ADDR_W-1:OFF];
          end
        end
        BURST: begin
          if (l2_ack) r_beat_idx <= r_beat_idx + ONE_BEAT;
        end
        DONE: r_last_owner <= r_owner;
        default: ;
      endcase
    end
  end

  assign w_burst    = (r_state == BURST);
  assign w_done     = (r_state == DONE);
  assign w_own_d    = (r_owner == OWN_D);
  assign w_ack_beat = w_burst && l2_ack;

  assign d_gnt    = (w_burst || w_done) && w_own_d;
  assign p_gnt    = (w_burst || w_done) && !w_own_d;
  assign d_beat   = w_ack_beat && w_own_d;
  assign p_beat   = w_ack_beat && !w_own_d;
  assign d_done   = w_done && w_own_d;
  assign p_done   = w_done && !w_own_d;
  assign rdata    = w_ack_beat ? l2_rdata : '0;
  assign l2_req   = w_burst;
  assign l2_we    = w_burst && r_we;
  assign l2_addr  = w_burst ? {r_line_addr, r_beat_idx, 2'b00} : '0;
  assign l2_wdata = (w_burst && w_own_d) ? d_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_l2_port_arbiter
// Brief  : Directed self-checking bench for l2_port_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_l2_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_req, d_we, p_req, l2_ack;
  logic [31:0] d_addr, d_wdata, p_addr, l2_rdata;
  logic        d_gnt, d_beat, d_done, p_gnt, p_beat, p_done, l2_req, l2_we;
  logic [31:0] rdata, l2_addr, l2_wdata;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  l2_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(8)) u_dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_beat(d_beat), .d_done(d_done),
    .p_req(p_req), .p_addr(p_addr),
    .p_gnt(p_gnt), .p_beat(p_beat), .p_done(p_done),
    .rdata(rdata), .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_ack(l2_ack), .l2_rdata(l2_rdata)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {d_gnt, d_beat, d_done, p_gnt, p_beat, p_done, l2_req, l2_we,
            l2_addr, l2_wdata, rdata};
  endfunction

  // Grants must never overlap.
  always @(negedge clk) check("gnt_excl", d_gnt & p_gnt, 0);

  // Entered at a negedge with the DUT in BURST beat 0 for the given owner.
  task automatic do_burst(input bit is_d, input logic [31:0] addr, input bit we,
                          input int gap, input int drop_at, input bit keep);
    logic [31:0] wd, rd, ea;
    for (int b = 0; b < 8; b++) begin
      wd = 32'hD000_0000 + 32'(b * 17) + addr;
      rd = 32'hA000_0000 + 32'(b * 3) + addr;
      ea = {addr[31:5], 3'(b), 2'b00};
      if (is_d) d_wdata = wd;
      l2_rdata = rd;
      l2_ack   = 1'b1;
      #1;
      check("burst_gnt", {d_gnt, p_gnt}, is_d ? 2'b10 : 2'b01);
      check("burst_beat", {d_beat, p_beat}, is_d ? 2'b10 : 2'b01);
      check("burst_l2req", l2_req, 1);
      check("burst_addr", l2_addr, ea);
      check("burst_we", l2_we, we);
      check("burst_rdata", rdata, rd);
      check("burst_wdata", l2_wdata, is_d ? wd : 32'h0);
      @(negedge clk);
      l2_ack   = 1'b0;
      l2_rdata = 32'h0;
      if (b == drop_at) begin
        if (is_d) begin
          d_req  = 1'b0;
          d_addr = ~d_addr;
          d_we   = ~d_we;
        end else begin
          p_req = 1'b0;
        end
      end
      if (b < 7) begin
        for (int g = 0; g < gap; g++) begin
          #1;
          check("gap_beat", {d_beat, p_beat}, 0);
          check("gap_addr", l2_addr, {addr[31:5], 3'(b + 1), 2'b00});
          @(negedge clk);
        end
      end
    end
    #1;
    check("done_pulse", {d_done, p_done}, is_d ? 2'b10 : 2'b01);
    check("done_gnt", {d_gnt, p_gnt}, is_d ? 2'b10 : 2'b01);
    check("done_l2", {l2_req, l2_we, l2_addr}, 0);
    if (!keep) begin
      if (is_d) d_req = 1'b0;
      else      p_req = 1'b0;
    end
    @(negedge clk);
    #1;
    check("idle_after", {d_done, p_done, d_gnt, p_gnt, l2_req}, 0);
  endtask

  initial begin
    reset = 1'b0; d_req = 0; d_we = 0; p_req = 0; l2_ack = 0;
    d_addr = 0; d_wdata = 0; p_addr = 0; l2_rdata = 0;
    repeat (2) @(negedge clk);
    #1 check("reset_outs", all_outs(), 0);
    reset = 1'b1;

    // Reset mid-burst at beat 3, then a write burst from a clean start.
    d_req = 1; d_we = 0; d_addr = 32'h0000_4440;
    @(negedge clk);
    #1 check("first_gnt", d_gnt, 1);
    for (int b = 0; b < 3; b++) begin
      l2_ack = 1; l2_rdata = 32'h1111_0000 + 32'(b);
      #1 check("pre_rst_beat", d_beat, 1);
      @(negedge clk);
      l2_ack = 0;
    end
    reset = 1'b0; l2_ack = 1; l2_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1 check("midrst_outs1", all_outs(), 0);
    @(negedge clk);
    #1 check("midrst_outs2", all_outs(), 0);
    l2_ack = 0; l2_rdata = 0;
    reset = 1'b1; d_we = 1; d_addr = 32'h0000_1234;
    @(negedge clk);
    #1 check("post_rst_gnt", d_gnt, 1);
    check("post_rst_addr", l2_addr, 32'h0000_1220);
    do_burst(1, 32'h0000_1234, 1, 0, -1, 0);

    // L1P read with ack pattern 1,0,0,1,...
    p_req = 1; p_addr = 32'h0000_8A64;
    @(negedge clk);
    do_burst(0, 32'h0000_8A64, 0, 2, -1, 0);

    // Tie from reset, then strict alternation over six bursts.
    reset = 1'b0; d_req = 1; d_we = 0; d_addr = 32'h0001_0000;
    p_req = 1; p_addr = 32'h0002_0020;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) do_burst(1, 32'h0001_0000, 0, 0, -1, i < 5);
      else            do_burst(0, 32'h0002_0020, 0, 0, -1, i < 5);
      if (i < 5) @(negedge clk);
    end
    d_req = 0;
    @(negedge clk);
    #1 check("tie_end_idle", {l2_req, d_gnt, p_gnt}, 0);

    // Request dropped after beat 2 plus address/direction churn mid-burst.
    d_req = 1; d_we = 0; d_addr = 32'h0003_0F80;
    @(negedge clk);
    do_burst(1, 32'h0003_0F80, 0, 1, 2, 0);
    l2_ack = 1; l2_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 check("idle_ack_ignored", {d_beat, p_beat, l2_req, rdata}, 0);
    end
    l2_ack = 0; l2_rdata = 0;

    // L1P request arriving during an L1D burst waits for IDLE.
    d_req = 1; d_we = 1; d_addr = 32'h0000_2000;
    @(negedge clk);
    p_req = 1; p_addr = 32'h0000_3004;
    do_burst(1, 32'h0000_2000, 1, 0, -1, 0);
    @(negedge clk);
    #1 check("p_wait_gnt", {d_gnt, p_gnt}, 2'b01);
    do_burst(0, 32'h0000_3004, 0, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
